dpi_mem_burst_port: RTL and testbench
=====================================

Name: dpi_mem_burst_port

Overview:
Parametrised successor to the single-beat DPI memory port: a burst-capable simulation memory front end that turns one request into N sequential DPI RAM accesses. Reads return through a configurable latency pipeline with a last-beat marker; writes stream at one beat per cycle with optional end-of-burst acknowledge. Sits between the arbiter/DMA engines and the C++ RAM model (dpi_read_ram / dpi_write_ram, 64-bit address and data).

Parameters:
ADDR_W, 64, request address width; zero-extended to 64 for DPI
DATA_W, 64, data width (1..64); zero-extended on write, truncated on read
LEN_W, 8, burst length field width; burst = req_len+1 beats
ADDR_STRIDE, 1, address increment per beat
READ_LAT, 1, cycles from read issue to valid (>=1; 1 = legacy timing)
WR_ACK, 0, 1 = pulse wack after final write beat; 0 = writes silent

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req  in  1  request strobe
req_ready  out  1  request accepted when req && req_ready
req_we  in  1  1 = write burst, 0 = read burst
req_addr  in  ADDR_W  start address
req_len  in  LEN_W  beats minus one
wvalid  in  1  write beat available
wready  out  1  write beat consumed when wvalid && wready
wdata  in  DATA_W  write beat data
valid  out  1  read data valid (reads only)
rdata  out  DATA_W  read data
rlast  out  1  with valid: final beat of read burst
wack  out  1  one-cycle write-burst-complete pulse (WR_ACK=1 only)
busy  out  1  burst in progress or read pipeline non-empty

Behaviour:
- Reset (rst_n=0, async): state IDLE, beat counter 0, pipeline valid bits 0; valid=0, rdata=0, rlast=0, wack=0, busy=0, wready=0. No DPI call in any cycle with rst_n=0.
- States: IDLE, RD, WR. req_ready = (state==IDLE), combinational.
- IDLE: on req && req_ready latch addr, cnt=req_len; go RD (req_we=0) or WR (req_we=1). No DPI call in accept cycle.
- RD: each cycle call dpi_read_ram(cur_addr), push {data, last=(cnt==0)} into pipeline stage 0; cur_addr += ADDR_STRIDE; cnt--. After beat with cnt==0, return to IDLE. Read stream never stalls (no backpressure on valid).
- Read latency: beat issued at edge k appears on valid/rdata/rlast after edge k+READ_LAT-1 (READ_LAT=1: visible cycle after issue, legacy). One beat per cycle, in order. rdata holds last value when valid=0.
- WR: wready=1. Each cycle with wvalid: dpi_write_ram(cur_addr, zero-ext wdata); advance addr/cnt. wvalid=0 stalls without DPI call. After final beat: IDLE; if WR_ACK=1, wack=1 for the next cycle only. valid never asserted for writes.
- New request accepted in IDLE while read pipeline still draining; ordering preserved since DPI reads complete at issue time. Back-to-back: accept cycle adds one idle cycle between bursts.
- Address arithmetic modulo 2^ADDR_W; wrap silently (0xFF..F + stride -> stride-1).
- busy = (state!=IDLE) || any pipeline stage valid.
- req while not ready: ignored, not queued.
- Reset mid-burst: burst aborted, in-flight read beats discarded, no wack; after release, IDLE and req_ready=1.
- req_len=0: single-beat burst, rlast on the only read beat.

Test Plan:
- Single read, READ_LAT=1: RAM[0x10]=0xDEAD, req addr 0x10 len 0 -> valid+rlast one cycle after issue, rdata=0xDEAD.
- Read burst, READ_LAT=3, len=3 from 0x100: valid on 4 consecutive cycles, data RAM[0x100..0x103], rlast only on 4th, first beat 3 cycles after first issue.
- Write burst len=7, wvalid toggling 1,0,1...: exactly 8 DPI writes to consecutive addresses, no valid; WR_ACK=1 -> single wack pulse after 8th beat; WR_ACK=0 -> none.
- DATA_W=32, ADDR_W=16: write 0xFFFF_FFFF at 0xFFFF, len=1 -> DPI addrs 0xFFFF then 0x0000, values zero-extended; readback truncated to 32 bits.
- rst_n asserted mid read burst (READ_LAT=4, beat 2 of 6): outputs zero immediately, no further DPI calls or valid, req_ready=1 after release.
- req held during RD burst: ignored until IDLE; second burst's data follows first with no reordering.

Source files
------------

// File: rtl/dpi_mem_burst_port.sv
// Burst front end for the simulation RAM: one request becomes req_len+1 sequential RAM
// accesses; read data returns through a READ_LAT-deep pipeline tagged with a last-beat flag.

package dpi_mem_burst_port_pkg;
    // Stand-in for the C++ RAM model behind the DPI entry points; logs keep call order.
    logic [63:0] ram [logic [63:0]];
    logic [63:0] rd_addr_log [$];
    logic [63:0] wr_addr_log [$];
    logic [63:0] wr_data_log [$];

    function automatic logic [63:0] dpi_read_ram(input logic [63:0] addr);
        rd_addr_log.push_back(addr);
        return ram.exists(addr) ? ram[addr] : 64'd0;
    endfunction

    function automatic void dpi_write_ram(input logic [63:0] addr, input logic [63:0] data);
        wr_addr_log.push_back(addr);
        wr_data_log.push_back(data);
        ram[addr] = data;
    endfunction
endpackage

module dpi_mem_burst_port
    import dpi_mem_burst_port_pkg::*;
#(
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 64,
    parameter int LEN_W       = 8,
    parameter int ADDR_STRIDE = 1,
    parameter int READ_LAT    = 1,
    parameter int WR_ACK      = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              wvalid,
    output logic              wready,
    input  logic [DATA_W-1:0] wdata,
    output logic              valid,
    output logic [DATA_W-1:0] rdata,
    output logic              rlast,
    output logic              wack,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   cur_addr;
    logic [LEN_W-1:0]    cnt;
    logic [READ_LAT-1:0] pipe_v;
    logic [READ_LAT-1:0] pipe_l;
    logic [DATA_W-1:0]   pipe_d [READ_LAT];
    logic                last_beat;

    assign last_beat = (cnt == '0);
    assign req_ready = (state == IDLE);
    assign wready    = (state == WR);
    assign busy      = (state != IDLE) || (|pipe_v);
    assign valid     = pipe_v[READ_LAT-1];
    assign rlast     = pipe_l[READ_LAT-1];
    assign rdata     = pipe_d[READ_LAT-1];

    // NOTE: every register here is assigned with <= so all updates see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cur_addr <= '0;
            cnt      <= '0;
            pipe_v   <= '0;
            pipe_l   <= '0;
            wack     <= 1'b0;
            // NOTE: the data pipeline is reset too, because its last stage is rdata itself.
            for (int i = 0; i < READ_LAT; i++) pipe_d[i] <= '0;
        end else begin
            wack      <= 1'b0;
            pipe_v[0] <= (state == RD);
            pipe_l[0] <= (state == RD) && last_beat;
            // Data only moves with a valid beat, so rdata holds between bursts.
            for (int i = 1; i < READ_LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_l[i] <= pipe_l[i-1];
                if (pipe_v[i-1]) pipe_d[i] <= pipe_d[i-1];
            end
            case (state)
                IDLE: begin
                    if (req) begin
                        cur_addr <= req_addr;
                        cnt      <= req_len;
                        state    <= req_we ? WR : RD;
                    end
                end
                RD: begin
                    pipe_d[0] <= DATA_W'(dpi_read_ram(64'(cur_addr)));
                    cur_addr  <= cur_addr + ADDR_W'(ADDR_STRIDE);
                    cnt       <= cnt - LEN_W'(1);
                    if (last_beat) state <= IDLE;
                end
                WR: begin
                    if (wvalid) begin
                        dpi_write_ram(64'(cur_addr), 64'(wdata));
                        cur_addr <= cur_addr + ADDR_W'(ADDR_STRIDE);
                        cnt      <= cnt - LEN_W'(1);
                        if (last_beat) begin
                            state <= IDLE;
                            wack  <= (WR_ACK != 0);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dpi_mem_burst_port.sv
// Self-checking bench: three differently parameterised ports share one RAM; an
// address-indexed reference RAM predicts every DPI call and every read beat.

module tb_dpi_mem_burst_port;
    import dpi_mem_burst_port_pkg::*;

    localparam int NI = 3;
    localparam int          LAT    [NI] = '{1, 3, 4};
    localparam int          ACK    [NI] = '{0, 1, 1};
    localparam int          STRIDE [NI] = '{3, 1, 1};
    localparam logic [63:0] AMASK  [NI] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF};
    localparam logic [63:0] DMASK  [NI] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        req_we = 1'b0;
    logic        wvalid = 1'b0;
    logic [63:0] req_addr = '0;
    logic [63:0] wdata = '0;
    logic [7:0]  req_len = '0;
    int          sel = 0;

    logic        rr [NI];
    logic        wrdy [NI];
    logic        vld [NI];
    logic        rl [NI];
    logic        wk [NI];
    logic        bz [NI];
    logic [63:0] rd0, rd1;
    logic [31:0] rd2;

    int checks = 0;
    int failures = 0;
    logic [63:0] model_ram [logic [63:0]];

    always #5 clk = ~clk;

    dpi_mem_burst_port #(.ADDR_STRIDE(3), .READ_LAT(1), .WR_ACK(0)) u_d0 (
        .clk(clk), .rst_n(rst_n), .req(req && sel == 0), .req_ready(rr[0]), .req_we(req_we),
        .req_addr(req_addr), .req_len(req_len), .wvalid(wvalid), .wready(wrdy[0]), .wdata(wdata),
        .valid(vld[0]), .rdata(rd0), .rlast(rl[0]), .wack(wk[0]), .busy(bz[0]));

    dpi_mem_burst_port #(.READ_LAT(3), .WR_ACK(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .req(req && sel == 1), .req_ready(rr[1]), .req_we(req_we),
        .req_addr(req_addr), .req_len(req_len), .wvalid(wvalid), .wready(wrdy[1]), .wdata(wdata),
        .valid(vld[1]), .rdata(rd1), .rlast(rl[1]), .wack(wk[1]), .busy(bz[1]));

    dpi_mem_burst_port #(.ADDR_W(16), .DATA_W(32), .READ_LAT(4), .WR_ACK(1)) u_d2 (
        .clk(clk), .rst_n(rst_n), .req(req && sel == 2), .req_ready(rr[2]), .req_we(req_we),
        .req_addr(req_addr[15:0]), .req_len(req_len), .wvalid(wvalid), .wready(wrdy[2]),
        .wdata(wdata[31:0]), .valid(vld[2]), .rdata(rd2), .rlast(rl[2]), .wack(wk[2]), .busy(bz[2]));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rdata_of(input int s);
        case (s)
            0:       return rd0;
            1:       return rd1;
            default: return {32'd0, rd2};
        endcase
    endfunction

    function automatic logic [63:0] model_rd(input logic [63:0] a);
        return model_ram.exists(a) ? model_ram[a] : 64'd0;
    endfunction

    function automatic logic [63:0] beat_addr(input int s, input logic [63:0] start, input int b);
        return (start + 64'(b) * 64'(STRIDE[s])) & AMASK[s];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for req_ready, presents the request, and returns just after the accept edge.
    task automatic issue(input int s, input bit we, input logic [63:0] addr, input int len);
        int guard = 0;
        sel = s;
        while (!rr[s] && guard < 200) begin
            step();
            guard++;
        end
        check("ready_before_req", 64'(rr[s]), 64'd1);
        req = 1'b1; req_we = we; req_addr = addr; req_len = 8'(len);
        step();
        req = 1'b0;
    endtask

    task automatic run_read(input int s, input logic [63:0] addr, input int len);
        logic [63:0] exp_a [$];
        logic [63:0] exp_d [$];
        logic [63:0] got_d [$];
        logic        got_l [$];
        int          got_c [$];
        int          base;
        for (int b = 0; b <= len; b++) begin
            exp_a.push_back(beat_addr(s, addr, b));
            exp_d.push_back(model_rd(beat_addr(s, addr, b)) & DMASK[s]);
        end
        base = rd_addr_log.size();
        issue(s, 1'b0, addr, len);
        for (int c = 1; c <= len + LAT[s] + 4; c++) begin
            step();
            if (vld[s]) begin
                got_d.push_back(rdata_of(s));
                got_l.push_back(rl[s]);
                got_c.push_back(c);
            end
        end
        check("rd_beat_count", 64'(got_d.size()), 64'(len + 1));
        for (int i = 0; i < got_d.size() && i <= len; i++) begin
            check("rd_beat_cycle", 64'(got_c[i]), 64'(LAT[s] + i));
            check("rd_data", got_d[i], exp_d[i]);
            check("rd_last", 64'(got_l[i]), 64'(i == len));
        end
        check("rd_dpi_count", 64'(rd_addr_log.size() - base), 64'(len + 1));
        for (int i = 0; i <= len && base + i < rd_addr_log.size(); i++)
            check("rd_dpi_addr", rd_addr_log[base + i], exp_a[i]);
        check("rd_idle_busy", 64'(bz[s]), 64'd0);
    endtask

    task automatic run_write(input int s, input logic [63:0] addr, input int len,
                             input bit toggle, input bit use_fix, input logic [63:0] fix);
        logic [63:0] exp_a [$];
        logic [63:0] exp_d [$];
        logic [63:0] d;
        int          base, n, c;
        logic        saw_valid, early_wack;
        base = wr_addr_log.size();
        issue(s, 1'b1, addr, len);
        n = 0; c = 0; saw_valid = 1'b0; early_wack = 1'b0;
        while (n <= len && c < 10 * (len + 1) + 20) begin
            wvalid = toggle ? (c % 2 == 0) : ($urandom_range(0, 3) != 0);
            d = use_fix ? fix : {$urandom, $urandom};
            wdata = d;
            check("wr_wready", 64'(wrdy[s]), 64'd1);
            if (wvalid) begin
                exp_a.push_back(beat_addr(s, addr, n));
                exp_d.push_back(d & DMASK[s]);
                model_ram[beat_addr(s, addr, n)] = d & DMASK[s];
                n++;
            end
            step();
            c++;
            saw_valid = saw_valid | vld[s];
            if (n <= len) early_wack = early_wack | wk[s];
        end
        wvalid = 1'b0;
        check("wr_wack_pulse", 64'(wk[s]), 64'(ACK[s]));
        step();
        check("wr_wack_cleared", 64'(wk[s]), 64'd0);
        check("wr_no_valid", 64'(saw_valid | vld[s]), 64'd0);
        check("wr_no_early_wack", 64'(early_wack), 64'd0);
        check("wr_ready_after", 64'(rr[s]), 64'd1);
        check("wr_dpi_count", 64'(wr_addr_log.size() - base), 64'(len + 1));
        for (int i = 0; i <= len && base + i < wr_addr_log.size(); i++) begin
            check("wr_dpi_addr", wr_addr_log[base + i], exp_a[i]);
            check("wr_dpi_data", wr_data_log[base + i], exp_d[i]);
        end
    endtask

    // req stays high through the first burst; it must be ignored until the port is idle again.
    task automatic run_held_req(input logic [63:0] a_addr, input int a_len,
                                input logic [63:0] b_addr, input int b_len);
        logic [63:0] exp_a [$];
        logic [63:0] exp_d [$];
        logic        exp_l [$];
        logic [63:0] got_d [$];
        logic        got_l [$];
        int          got_c [$];
        int          base, acc;
        for (int b = 0; b <= a_len; b++) begin
            exp_a.push_back(beat_addr(1, a_addr, b));
            exp_d.push_back(model_rd(beat_addr(1, a_addr, b)));
            exp_l.push_back(b == a_len);
        end
        for (int b = 0; b <= b_len; b++) begin
            exp_a.push_back(beat_addr(1, b_addr, b));
            exp_d.push_back(model_rd(beat_addr(1, b_addr, b)));
            exp_l.push_back(b == b_len);
        end
        base = rd_addr_log.size();
        sel = 1;
        check("held_ready_start", 64'(rr[1]), 64'd1);
        req = 1'b1; req_we = 1'b0; req_addr = a_addr; req_len = 8'(a_len); acc = 0;
        for (int c = 1; c <= a_len + b_len + 2 * LAT[1] + 12; c++) begin
            if (req && rr[1]) acc++;
            step();
            if (acc == 1) begin
                req_addr = b_addr;
                req_len  = 8'(b_len);
            end
            if (acc == 2) req = 1'b0;
            if (vld[1]) begin
                got_d.push_back(rd1);
                got_l.push_back(rl[1]);
                got_c.push_back(c);
            end
        end
        req = 1'b0;
        check("held_accepts", 64'(acc), 64'd2);
        check("held_beats", 64'(got_d.size()), 64'(exp_d.size()));
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
            check("held_data", got_d[i], exp_d[i]);
            check("held_last", 64'(got_l[i]), 64'(exp_l[i]));
        end
        if (got_c.size() > a_len + 1)
            check("held_gap", 64'(got_c[a_len + 1] - got_c[a_len]), 64'd2);
        check("held_dpi_count", 64'(rd_addr_log.size() - base), 64'(exp_a.size()));
        for (int i = 0; i < exp_a.size() && base + i < rd_addr_log.size(); i++)
            check("held_dpi_addr", rd_addr_log[base + i], exp_a[i]);
    endtask

    initial begin
        int base;
        // Reset with a request pending: nothing may reach the RAM.
        sel = 0; req = 1'b1; req_we = 1'b0; req_addr = 64'h40;
        repeat (3) step();
        for (int i = 0; i < NI; i++) begin
            check("rst_valid", 64'(vld[i]), 64'd0);
            check("rst_rlast", 64'(rl[i]), 64'd0);
            check("rst_wack", 64'(wk[i]), 64'd0);
            check("rst_busy", 64'(bz[i]), 64'd0);
            check("rst_wready", 64'(wrdy[i]), 64'd0);
            check("rst_rdata", rdata_of(i), 64'd0);
        end
        check("rst_no_dpi", 64'(rd_addr_log.size() + wr_addr_log.size()), 64'd0);
        req = 1'b0;
        rst_n = 1'b1;
        step();

        // Legacy single beat, then a latency-3 burst.
        run_write(0, 64'h10, 0, 1'b0, 1'b1, 64'hDEAD);
        run_read(0, 64'h10, 0);
        run_write(1, 64'h100, 3, 1'b0, 1'b0, 64'd0);
        run_read(1, 64'h100, 3);

        // Toggling wvalid, with and without end-of-burst acknowledge.
        run_write(1, 64'h500, 7, 1'b1, 1'b0, 64'd0);
        run_write(0, 64'h600, 7, 1'b1, 1'b0, 64'd0);
        run_read(0, 64'h600, 7);

        // Narrow port: address wrap at 0xFFFF, zero-extended writes, truncated reads.
        run_write(2, 64'hFFFF, 1, 1'b0, 1'b1, 64'hA5A5_A5A5_FFFF_FFFF);
        run_read(2, 64'hFFFF, 1);
        run_write(0, 64'h2000, 0, 1'b0, 1'b0, 64'd0);
        run_read(2, 64'h2000, 0);

        // Full 64-bit address wrap with stride 3.
        run_write(0, 64'hFFFF_FFFF_FFFF_FFFE, 3, 1'b0, 1'b0, 64'd0);
        run_read(0, 64'hFFFF_FFFF_FFFF_FFFE, 3);

        run_held_req(64'h100, 3, 64'h500, 2);

        for (int it = 0; it < 14; it++) begin
            int          s;
            int          len;
            logic [63:0] a;
            s   = it % 2;
            len = $urandom_range(0, 7);
            a   = 64'h4000 + 64'($urandom_range(0, 40));
            if (it < 4 || $urandom_range(0, 1) == 1) run_write(s, a, len, 1'b0, 1'b0, 64'd0);
            else                                     run_read(s, a, len);
        end

        // Reset in the middle of a latency-4 read burst, after two of six beats issued.
        base = rd_addr_log.size();
        issue(2, 1'b0, 64'h0010, 5);
        step();
        step();
        check("mid_issued", 64'(rd_addr_log.size() - base), 64'd2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(vld[2]), 64'd0);
        check("mid_rst_rdata", rdata_of(2), 64'd0);
        check("mid_rst_rlast", 64'(rl[2]), 64'd0);
        check("mid_rst_busy", 64'(bz[2]), 64'd0);
        check("mid_rst_ready", 64'(rr[2]), 64'd1);
        repeat (3) step();
        rst_n = 1'b1;
        begin
            logic saw_valid;
            saw_valid = 1'b0;
            repeat (8) begin
                step();
                saw_valid = saw_valid | vld[2];
            end
            check("mid_no_valid_after", 64'(saw_valid), 64'd0);
        end
        check("mid_no_more_dpi", 64'(rd_addr_log.size() - base), 64'd2);
        check("mid_ready_after", 64'(rr[2]), 64'd1);
        run_read(2, 64'hFFFF, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
